// File: rtl/lbp_pkg.sv
// Shared geometry, FSM encoding and border decode for the LBP image host.
// Imported by the host interface, RAM and top.
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int ADDR_W = 14;
    localparam int PIX_W  = 8;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = ADDR_W - COL_W;
    localparam int NPIX  = IMG_W * IMG_H;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(IMG_H - 1);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PIX_W-1:0]  pix_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Outermost ring of the image: LBP codes are undefined there.
    function automatic logic is_border(input addr_t a);
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        row = a[ADDR_W-1:COL_W];
        col = a[COL_W-1:0];
        return (row == '0) || (row == ROW_MAX) ||
               (col == '0) || (col == '1);
    endfunction

endpackage

// File: rtl/lbp_image_host_if.sv
// Engine-side bus of the LBP image host: gray reads, LBP writes, finish.
// master = LBP engine, slave = image host.
interface lbp_image_host_if;
    import lbp_pkg::*;

    addr_t gray_addr;
    logic  gray_req;
    logic  gray_ready;
    pix_t  gray_data;
    addr_t lbp_addr;
    logic  lbp_valid;
    pix_t  lbp_data;
    logic  finish;

    modport master (
        output gray_addr, gray_req,
        output lbp_addr, lbp_valid, lbp_data, finish,
        input  gray_ready, gray_data
    );

    modport slave (
        input  gray_addr, gray_req,
        input  lbp_addr, lbp_valid, lbp_data, finish,
        output gray_ready, gray_data
    );

endinterface

// File: rtl/lbp_host_ram.sv
// Simple dual-port RAM: one write port, one read port.
// Ports: clk, we/waddr/wdata write side; raddr/rdata read side (REG_READ picks async or 1-cycle).
module lbp_host_ram
    import lbp_pkg::*;
#(
    parameter int AW       = ADDR_W,
    parameter int DW       = PIX_W,
    parameter bit REG_READ = 1'b0
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ) begin : g_reg
            logic [DW-1:0] q;
            always_ff @(posedge clk) begin
                q <= mem[raddr];
            end
            assign rdata = q;
        end else begin : g_async
            assign rdata = mem[raddr];
        end
    endgenerate

endmodule

// File: rtl/lbp_image_host.sv
// LBP image host: holds the gray image, serves engine reads, captures LBP results.
// Ports: clk/reset, ld_* raster load, eng (slave bus), rd_* readout, done/wr_count/err_* status.
module lbp_image_host
    import lbp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  pix_t              ld_data,
    output logic              ld_ready,
    lbp_image_host_if.slave   eng,
    input  addr_t             rd_addr,
    output pix_t              rd_data,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic              err_border,
    output logic              err_early
);

    state_t state;
    state_t state_nxt;
    addr_t  ptr;
    logic   gray_rdy;
    pix_t   gray_q;
    pix_t   lbp_q;
    logic   rd_zero_q;

    logic load_beat;
    logic lbp_serve;
    logic lbp_border;
    logic lbp_we;
    logic early;

    assign load_beat  = (state == LOAD) && ld_valid;
    assign lbp_serve  = (state == SERVE) && eng.lbp_valid;
    assign lbp_border = is_border(eng.lbp_addr);
    assign lbp_we     = lbp_serve && !lbp_border;
    assign early      = ((state == LOAD) && (eng.lbp_valid || eng.finish)) ||
                        ((state == DONE) && eng.lbp_valid);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == LOAD): begin
                if (load_beat && (ptr == LAST_PIX)) begin
                    state_nxt = SERVE;
                end
            end
            (state == SERVE): begin
                if (eng.finish) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Moore outputs
    always_comb begin
        ld_ready = 1'b0;
        gray_rdy = 1'b0;
        done     = 1'b0;
        unique case (1'b1)
            (state == LOAD):  ld_ready = 1'b1;
            (state == SERVE): gray_rdy = 1'b1;
            (state == DONE): begin
                gray_rdy = 1'b1;
                done     = 1'b1;
            end
            default: ld_ready = 1'b0;
        endcase
    end

    assign eng.gray_ready = gray_rdy;
    assign eng.gray_data  = (gray_rdy && eng.gray_req) ? gray_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            wr_count   <= '0;
            err_border <= 1'b0;
            err_early  <= 1'b0;
        end else begin
            if (load_beat) begin
                ptr <= ptr + 1'b1;
            end
            if (lbp_we && (wr_count != '1)) begin
                wr_count <= wr_count + 1'b1;
            end
            if (lbp_serve && lbp_border) begin
                err_border <= 1'b1;
            end
            if (early) begin
                err_early <= 1'b1;
            end
        end
    end

    // The result RAM output is not reset, so a registered zero-mask
    // forces rd_data to 0 out of reset and for border addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_zero_q <= 1'b1;
        end else begin
            rd_zero_q <= is_border(rd_addr);
        end
    end

    assign rd_data = rd_zero_q ? '0 : lbp_q;

    lbp_host_ram #(
        .AW       (ADDR_W),
        .DW       (PIX_W),
        .REG_READ (1'b0)
    ) u_gray (
        .clk   (clk),
        .we    (load_beat),
        .waddr (ptr),
        .wdata (ld_data),
        .raddr (eng.gray_addr),
        .rdata (gray_q)
    );

    lbp_host_ram #(
        .AW       (ADDR_W),
        .DW       (PIX_W),
        .REG_READ (1'b1)
    ) u_lbp (
        .clk   (clk),
        .we    (lbp_we),
        .waddr (eng.lbp_addr),
        .wdata (eng.lbp_data),
        .raddr (rd_addr),
        .rdata (lbp_q)
    );

endmodule

// File: tb/tb_lbp_image_host.sv
// Testbench for lbp_image_host: randomized load/serve/readout against a behavioural model.
// Drives the engine bus through an interface instance.
module tb_lbp_image_host;

    localparam int W    = 128;
    localparam int H    = 128;
    localparam int N    = W * H;
    localparam int LAST_NB = (H - 2) * W + (W - 2);

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        done;
    logic [14:0] wr_count;
    logic        err_border;
    logic        err_early;

    lbp_image_host_if eng ();

    lbp_image_host dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .eng        (eng.slave),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .done       (done),
        .wr_count   (wr_count),
        .err_border (err_border),
        .err_early  (err_early)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] gray_m [N];
    logic [7:0] lbp_m  [N];
    int         m_count;

    function automatic bit border_m(input int a);
        int r;
        int c;
        r = a / W;
        c = a % W;
        return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    endfunction

    function automatic int rand_nb();
        int a;
        do a = int'($urandom_range(0, N - 1)); while (border_m(a));
        return a;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid       = 1'b0;
        ld_data        = '0;
        rd_addr        = '0;
        eng.gray_addr  = '0;
        eng.gray_req   = 1'b0;
        eng.lbp_addr   = '0;
        eng.lbp_valid  = 1'b0;
        eng.lbp_data   = '0;
        eng.finish     = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_count = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        eng.gray_req = 1'b1;
        eng.gray_addr = 14'd129;
        reset = 1'b1;
        step();
        step();
        n_chk++;
        if (ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_ld_ready: got %b want 1", ld_ready);
        end
        n_chk++;
        if (eng.gray_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_gray_ready: got %b want 0", eng.gray_ready);
        end
        n_chk++;
        if (eng.gray_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_gray_data: got %h want 00", eng.gray_data);
        end
        n_chk++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_rd_data: got %h want 00", rd_data);
        end
        n_chk++;
        if (done !== 1'b0 || err_border !== 1'b0 || err_early !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags: got done=%b eb=%b ee=%b want 0 0 0",
                     done, err_border, err_early);
        end
        n_chk++;
        if (wr_count !== 15'd0) begin
            n_fail++; $display("FAIL rst_wr_count: got %0d want 0", wr_count);
        end
        reset = 1'b0;
        m_count = 0;
        idle_inputs();
    endtask

    task automatic test_load(input int gap_pct);
        int b;
        int bad;
        b = 0;
        bad = 0;
        while (b < N) begin
            if (eng.gray_ready !== 1'b0 || ld_ready !== 1'b1) bad++;
            ld_valid = ($urandom_range(0, 99) >= gap_pct);
            if (ld_valid) begin
                ld_data = 8'(b);
                gray_m[b] = 8'(b);
            end else begin
                ld_data = 8'($urandom);
            end
            step();
            if (ld_valid) b++;
        end
        ld_valid = 1'b0;
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL load_early_ready: got %0d bad cycles want 0", bad);
        end
        n_chk++;
        if (eng.gray_ready !== 1'b1 || ld_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_switch: got gray_ready=%b ld_ready=%b want 1 0",
                     eng.gray_ready, ld_ready);
        end
    endtask

    task automatic test_gray_read();
        logic [13:0] a;
        logic [7:0]  exp;
        eng.gray_req  = 1'b1;
        eng.gray_addr = 14'd129;
        #1;
        n_chk++;
        if (eng.gray_data !== 8'h81) begin
            n_fail++; $display("FAIL gray_129: got %h want 81", eng.gray_data);
        end
        eng.gray_req = 1'b0;
        #1;
        n_chk++;
        if (eng.gray_data !== 8'h00) begin
            n_fail++; $display("FAIL gray_noreq: got %h want 00", eng.gray_data);
        end
        for (int i = 0; i < 24; i++) begin
            a = 14'($urandom);
            eng.gray_addr = a;
            eng.gray_req  = $urandom_range(0, 3) != 0;
            exp = eng.gray_req ? gray_m[a] : 8'h00;
            #1;
            n_chk++;
            if (eng.gray_data !== exp) begin
                n_fail++;
                $display("FAIL gray_rand: addr %0d req %b got %h want %h",
                         a, eng.gray_req, eng.gray_data, exp);
            end
            if (i % 4 == 0) step();
        end
        eng.gray_req = 1'b0;
        step();
    endtask

    task automatic test_write_readback();
        int addrs [20];
        eng.lbp_addr  = 14'd129;
        eng.lbp_data  = 8'hA5;
        eng.lbp_valid = 1'b1;
        lbp_m[129] = 8'hA5;
        m_count++;
        step();
        eng.lbp_valid = 1'b0;
        rd_addr = 14'd129;
        step();
        n_chk++;
        if (rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL rd_129: got %h want a5", rd_data);
        end
        n_chk++;
        if (wr_count !== 15'd1) begin
            n_fail++; $display("FAIL wr_count_1: got %0d want 1", wr_count);
        end
        for (int i = 0; i < 20; i++) begin
            addrs[i] = (i == 7) ? addrs[2] : rand_nb();
            eng.lbp_addr  = 14'(addrs[i]);
            eng.lbp_data  = 8'($urandom);
            eng.lbp_valid = $urandom_range(0, 4) != 0;
            if (eng.lbp_valid) begin
                lbp_m[addrs[i]] = eng.lbp_data;
                m_count++;
            end
            step();
        end
        eng.lbp_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_addr = 14'(addrs[i]);
            step();
            n_chk++;
            if (rd_data !== lbp_m[addrs[i]]) begin
                n_fail++;
                $display("FAIL rd_rand: addr %0d got %h want %h",
                         addrs[i], rd_data, lbp_m[addrs[i]]);
            end
        end
        n_chk++;
        if (wr_count !== 15'(m_count)) begin
            n_fail++; $display("FAIL wr_count_rand: got %0d want %0d", wr_count, m_count);
        end
    endtask

    task automatic test_border();
        eng.lbp_valid = 1'b1;
        eng.lbp_addr  = 14'd127;
        eng.lbp_data  = 8'h3C;
        step();
        eng.lbp_addr  = 14'd16256;
        eng.lbp_data  = 8'hC3;
        step();
        eng.lbp_valid = 1'b0;
        n_chk++;
        if (err_border !== 1'b1) begin
            n_fail++; $display("FAIL border_flag: got %b want 1", err_border);
        end
        n_chk++;
        if (wr_count !== 15'(m_count)) begin
            n_fail++; $display("FAIL border_count: got %0d want %0d", wr_count, m_count);
        end
        n_chk++;
        if (err_early !== 1'b0) begin
            n_fail++; $display("FAIL border_early: got %b want 0", err_early);
        end
        rd_addr = 14'd127;
        step();
        n_chk++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL border_rd127: got %h want 00", rd_data);
        end
        rd_addr = 14'd16256;
        step();
        n_chk++;
        if (rd_data !== 8'h00) begin
            n_fail++; $display("FAIL border_rd16256: got %h want 00", rd_data);
        end
    endtask

    task automatic test_reset_mid_serve();
        int a;
        for (int i = 0; i < 100; i++) begin
            a = rand_nb();
            eng.lbp_addr  = 14'(a);
            eng.lbp_data  = 8'($urandom);
            eng.lbp_valid = 1'b1;
            lbp_m[a] = eng.lbp_data;
            m_count++;
            step();
        end
        eng.lbp_valid = 1'b0;
        n_chk++;
        if (wr_count !== 15'(m_count)) begin
            n_fail++; $display("FAIL pre_reset_count: got %0d want %0d", wr_count, m_count);
        end
        apply_reset();
        n_chk++;
        if (ld_ready !== 1'b1 || eng.gray_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_state: got ld_ready=%b gray_ready=%b done=%b want 1 0 0",
                     ld_ready, eng.gray_ready, done);
        end
        n_chk++;
        if (wr_count !== 15'd0 || err_border !== 1'b0 || err_early !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: got cnt=%0d eb=%b ee=%b want 0 0 0",
                     wr_count, err_border, err_early);
        end
        eng.lbp_addr  = 14'd200;
        eng.lbp_data  = 8'h77;
        eng.lbp_valid = 1'b1;
        step();
        eng.lbp_valid = 1'b0;
        n_chk++;
        if (err_early !== 1'b1 || wr_count !== 15'd0) begin
            n_fail++;
            $display("FAIL early_write: got ee=%b cnt=%0d want 1 0", err_early, wr_count);
        end
        eng.finish = 1'b1;
        step();
        eng.finish = 1'b0;
        step();
        n_chk++;
        if (ld_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL early_finish: got ld_ready=%b done=%b want 1 0", ld_ready, done);
        end
        apply_reset();
        n_chk++;
        if (err_early !== 1'b0) begin
            n_fail++; $display("FAIL reset_clears_early: got %b want 0", err_early);
        end
    endtask

    task automatic test_full_run();
        int a;
        for (int i = 0; i < N; i++) begin
            if (!border_m(i)) begin
                eng.lbp_addr  = 14'(i);
                eng.lbp_data  = 8'($urandom);
                eng.lbp_valid = 1'b1;
                lbp_m[i] = eng.lbp_data;
                m_count++;
                if (i == LAST_NB) begin
                    eng.finish = 1'b1;
                    n_chk++;
                    if (done !== 1'b0) begin
                        n_fail++; $display("FAIL done_before_finish: got %b want 0", done);
                    end
                end
                step();
            end
        end
        eng.lbp_valid = 1'b0;
        eng.finish    = 1'b0;
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL done_after_finish: got %b want 1", done);
        end
        n_chk++;
        if (wr_count !== 15'd15876) begin
            n_fail++; $display("FAIL full_count: got %0d want 15876", wr_count);
        end
        n_chk++;
        if (err_border !== 1'b0 || err_early !== 1'b0 || eng.gray_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_flags: got eb=%b ee=%b gr=%b want 0 0 1",
                     err_border, err_early, eng.gray_ready);
        end
        for (int i = 0; i < N; i++) begin
            if (border_m(i)) begin
                rd_addr = 14'(i);
                step();
                n_chk++;
                if (rd_data !== 8'h00) begin
                    n_fail++; $display("FAIL border_rd: addr %0d got %h want 00", i, rd_data);
                end
            end
        end
        for (int i = 0; i < 200; i++) begin
            a = rand_nb();
            rd_addr = 14'(a);
            step();
            n_chk++;
            if (rd_data !== lbp_m[a]) begin
                n_fail++;
                $display("FAIL full_rd: addr %0d got %h want %h", a, rd_data, lbp_m[a]);
            end
        end
    endtask

    task automatic test_done_state();
        int a;
        logic [13:0] g;
        a = rand_nb();
        eng.lbp_addr  = 14'(a);
        eng.lbp_data  = ~lbp_m[a];
        eng.lbp_valid = 1'b1;
        step();
        eng.lbp_valid = 1'b0;
        n_chk++;
        if (err_early !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_write_flag: got ee=%b done=%b want 1 1", err_early, done);
        end
        n_chk++;
        if (wr_count !== 15'd15876) begin
            n_fail++; $display("FAIL done_write_count: got %0d want 15876", wr_count);
        end
        rd_addr = 14'(a);
        step();
        n_chk++;
        if (rd_data !== lbp_m[a]) begin
            n_fail++;
            $display("FAIL done_write_dropped: addr %0d got %h want %h", a, rd_data, lbp_m[a]);
        end
        g = 14'($urandom);
        eng.gray_addr = g;
        eng.gray_req  = 1'b1;
        #1;
        n_chk++;
        if (eng.gray_data !== gray_m[g]) begin
            n_fail++;
            $display("FAIL done_gray: addr %0d got %h want %h", g, eng.gray_data, gray_m[g]);
        end
        eng.gray_req = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        m_count = 0;
        idle_inputs();
        test_reset();
        test_load(30);
        test_gray_read();
        test_write_readback();
        test_border();
        test_reset_mid_serve();
        test_load(10);
        test_full_run();
        test_done_state();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lbp_image_host.md
Name: lbp_image_host

Overview:
- Responder/memory end of the LBP gray-read and lbp-write interface.
- Holds the 128x128 8-bit gray image and serves combinational reads to the LBP engine.
- Captures the engine's LBP result writes into a result memory and tracks write count, protocol errors and completion.
- Image load and result readout ports face the system/testbench side.

Parameters:
- IMG_W, 128, image width in pixels (power of two)
- IMG_H, 128, image height in pixels
- ADDR_W, 14, pixel address width (log2(IMG_W*IMG_H))
- PIX_W, 8, pixel / LBP code width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  load beat valid; pixels arrive in raster order
- ld_data  in  PIX_W  load pixel
- ld_ready  out  1  high while in LOAD state
- gray_addr  in  ADDR_W  read address from engine
- gray_req  in  1  read request from engine
- gray_ready  out  1  image fully loaded and servable
- gray_data  out  PIX_W  read data
- lbp_addr  in  ADDR_W  result write address
- lbp_valid  in  1  result write strobe
- lbp_data  in  PIX_W  result write data
- finish  in  1  engine done
- rd_addr  in  ADDR_W  result readout address
- rd_data  out  PIX_W  result readout data, registered
- done  out  1  finish accepted
- wr_count  out  ADDR_W+1  accepted result writes
- err_border  out  1  sticky: write to a border address
- err_early  out  1  sticky: lbp_valid or finish seen outside SERVE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state=LOAD, ld_ready=1, gray_ready=0, gray_data=0, rd_data=0, done=0, wr_count=0, err_border=0, err_early=0, load pointer=0.
- Memory arrays are not cleared by reset. A reset at any point, including mid-load or mid-serve, returns to LOAD and requires a full reload.
- LOAD state:
  - Each cycle with ld_valid=1 writes mem_gray[ptr]=ld_data and increments ptr.
  - The beat with ptr==IMG_W*IMG_H-1 moves the block to SERVE on the next edge. gray_ready and ld_ready both switch in that same cycle.
  - ld_valid gaps are allowed; ptr holds during a gap.
- SERVE state:
  - gray_data = mem_gray[gray_addr] when gray_req=1, else 0. This path is purely combinational (zero latency): the engine updates gray_addr on an edge and samples gray_data on the next edge.
  - lbp_valid=1 on a non-border address writes mem_lbp[lbp_addr]=lbp_data and increments wr_count (saturating).
  - lbp_valid=1 on a border address (row 0, row IMG_H-1, col 0, col IMG_W-1) drops the write and sets err_border.
  - A repeated write to the same address overwrites and still counts.
  - finish=1 moves the block to DONE on the next edge; done=1 from that edge.
  - lbp_valid and finish in the same cycle: the write is accepted first, then the transition happens.
- DONE state:
  - done stays 1; gray_ready stays 1 and reads remain served.
  - Further lbp_valid is ignored and sets err_early.
  - Exit only by reset.
- err_early is also set by lbp_valid or finish during LOAD; the write or finish is ignored.
- Readout: rd_data is registered with 1-cycle latency and is available in every state. Border addresses return 0 by address decode. Non-border addresses return mem_lbp contents, which are undefined until written.
- Border test: row = addr[ADDR_W-1:log2(IMG_W)], col = addr[log2(IMG_W)-1:0].

Decomposition:
- Package lbp_pkg holds:
  - IMG_W, IMG_H, ADDR_W, PIX_W
  - state encoding LOAD=0, SERVE=1, DONE=2
  - is_border(addr) function
- Sub-module lbp_host_ram: one write port and one read port, with the read mode selectable between async and registered by parameter.
  - Instantiated twice: gray in async-read mode, lbp in registered-read mode.

Test Plan:
- Load ramp pixel(a)=a[7:0] with random ld_valid gaps -> gray_ready rises exactly after the 16384th beat; ld_ready falls in the same cycle.
- SERVE, gray_req=1, gray_addr=129 -> gray_data=0x81 in the same cycle. Drop gray_req to 0 -> gray_data=0.
- lbp_valid with lbp_addr=129, lbp_data=0xA5 -> rd_addr=129 returns 0xA5 one cycle later; wr_count=1.
- lbp_valid with lbp_addr=127 (col 127) and lbp_addr=16256 (row 127) -> err_border=1, wr_count unchanged, rd_data=0.
- Full engine run on the ramp image -> wr_count=15876; finish leads to done=1 next edge; all border reads return 0.
- Reset asserted mid-SERVE after 100 writes -> state LOAD, gray_ready=0, wr_count=0, errors clear; lbp_valid before reload sets err_early.
